// File: rtl/lbp_img_host.sv
// lbp_img_host
//   Host-side memory front end for the LBP engine. A raster-order byte
//   stream loads the gray image. The engine then reads pixels through
//   gray_req/gray_addr with 1-cycle latency, and writes results through
//   lbp_valid/lbp_addr. After finish, the full result image is streamed out
//   with valid/ready handshaking.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   pix_valid/data/ready     gray image load stream (raster order)
//   gray_req/addr/ready/data engine read port (gray_ready = serving reads)
//   lbp_valid/addr/data      engine result write port
//   finish                   engine done, starts the result dump
//   res_valid/data/last/ready result stream; res_last marks beat N-1
//   lbp_count                accepted result writes (saturating)
//   proto_err                sticky protocol-error flag
//   done                     result dump complete (sticky until reset)
module lbp_img_host #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_valid,
  input  logic [7:0]    pix_data,
  output logic          pix_ready,
  input  logic          gray_req,
  input  logic [AW-1:0] gray_addr,
  output logic          gray_ready,
  output logic [7:0]    gray_data,
  input  logic          lbp_valid,
  input  logic [AW-1:0] lbp_addr,
  input  logic [7:0]    lbp_data,
  input  logic          finish,
  output logic          res_valid,
  output logic [7:0]    res_data,
  output logic          res_last,
  input  logic          res_ready,
  output logic [AW:0]   lbp_count,
  output logic          proto_err,
  output logic          done
);

  localparam int          N      = IMG_W * IMG_H;
  localparam logic [AW:0] N_L    = (AW+1)'(N);
  localparam logic [AW:0] LAST_L = (AW+1)'(N - 1);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_SERVE = 2'd1;
  localparam logic [1:0] ST_DUMP  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]  state, state_nxt;
  // Shared pointer: load address in LOAD, next dump index in DUMP.
  // One bit wider than an address so it can reach N.
  logic [AW:0] ptr;

  logic [7:0] img_mem [0:(1<<AW)-1];
  logic [7:0] res_mem [0:(1<<AW)-1];

  logic gray_addr_ok, lbp_addr_ok;
  logic load_beat, lbp_wr, dump_load, dump_xfer;

  assign gray_addr_ok = ({1'b0, gray_addr} < N_L);
  assign lbp_addr_ok  = ({1'b0, lbp_addr} < N_L);

  assign load_beat = !reset && (state == ST_LOAD) && pix_valid && pix_ready;
  assign lbp_wr    = !reset && (state == ST_SERVE) && lbp_valid && lbp_addr_ok;
  // Refill the output register when it is empty or being drained this cycle.
  assign dump_load = (state == ST_DUMP) && (ptr < N_L) && (!res_valid || res_ready);
  assign dump_xfer = res_valid && res_ready;

  assign gray_ready = (state == ST_SERVE);
  assign done       = (state == ST_DONE);

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      ST_LOAD:  if (load_beat && ptr == LAST_L) state_nxt = ST_SERVE;
      ST_SERVE: if (finish) state_nxt = ST_DUMP;
      ST_DUMP:  if (dump_xfer && res_last) state_nxt = ST_DONE;
      default:  state_nxt = state;
    endcase
  end

  // NOTE: RAM arrays sit in their own reset-free block so they map onto
  // block RAM; their contents are undefined until loaded.
  always_ff @(posedge clk) begin
    if (load_beat) begin
      img_mem[ptr[AW-1:0]] <= pix_data;
      // Clear the result slot too, so border pixels the engine never writes
      // dump as zero instead of stale data from an earlier run.
      res_mem[ptr[AW-1:0]] <= 8'h00;
    end else if (lbp_wr) begin
      res_mem[lbp_addr] <= lbp_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_LOAD;
      ptr       <= '0;
      pix_ready <= 1'b0;
      gray_data <= 8'h00;
      res_valid <= 1'b0;
      res_data  <= 8'h00;
      res_last  <= 1'b0;
      lbp_count <= '0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      pix_ready <= (state_nxt == ST_LOAD);

      case (state)
        ST_LOAD:  if (load_beat) ptr <= ptr + 1'b1;
        ST_SERVE: if (finish) ptr <= '0;
        ST_DUMP: begin
          if (dump_load) begin
            res_data  <= res_mem[ptr[AW-1:0]];
            res_last  <= (ptr == LAST_L);
            res_valid <= 1'b1;
            ptr       <= ptr + 1'b1;
          end else if (dump_xfer) begin
            res_valid <= 1'b0;
            res_last  <= 1'b0;
          end
        end
        default: ;
      endcase

      if (gray_req) begin
        if (state != ST_SERVE) begin
          proto_err <= 1'b1;
        end else if (gray_addr_ok) begin
          gray_data <= img_mem[gray_addr];
        end else begin
          gray_data <= 8'h00;
          proto_err <= 1'b1;
        end
      end

      if (lbp_valid) begin
        if (lbp_wr) begin
          if (lbp_count != '1) lbp_count <= lbp_count + 1'b1;
        end else begin
          proto_err <= 1'b1;
        end
      end

      if (finish && state == ST_LOAD) proto_err <= 1'b1;
    end
  end

endmodule
